sipo_frame_ctrl: RTL and testbench

//  Sequences a serial-in/parallel-out shift register: frames a serial bit stream on a start strobe,

---
 rtl/sipo_pkg.sv | 12 +
 rtl/sipo_shift_core.sv | 30 +++
 rtl/sipo_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the SIPO frame controller: FSM state encoding and default word width.
package sipo_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit MSB-first shift register with shift enable and synchronous clear.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

    // Look-ahead view: while shifting, the word as it will be after this bit lands.
    assign word = en ? {q[WIDTH-2:0], din} : q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frames a serial stream into WIDTH-bit words and offers them on a valid/ready output.
// Optional trailing parity bit and parity_err output when SIPO_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; a start here samples data bit 0
// SHIFT  | sampling data bits 1..WIDTH-1, one per clock
// PARITY | sampling the trailing parity bit (SIPO_PARITY_EN only)
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef SIPO_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             start,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic             shift_en;
    logic             shift_clr;
    logic             done;

    assign shift_en  = ((state == IDLE) && start) || (state == SHIFT);
    assign shift_clr = (state == IDLE) && !start;
    assign busy      = (state != IDLE);

`ifdef SIPO_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    assign done = (state == PARITY);
`else
    assign done = (state == SHIFT) && (cnt == LAST);
`endif

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (shift_clr),
        .en   (shift_en),
        .din  (ser_in),
        .word (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= CW'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef SIPO_PARITY_EN
                        state <= PARITY;
                        cnt   <= CW'(WIDTH);
`else
                        state <= IDLE;
                        cnt   <= '0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // A held, unaccepted word wins over a newly completed one.
            if (done && (!dout_valid || dout_ready)) begin
                dout       <= word;
                dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err <= (^word) ^ ser_in ^ ODD;
`endif
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (done && dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4): table of single frames plus multi-cycle sequences.
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ser_in;
    logic         start;
    logic         ovr_clr;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;
`ifdef SIPO_PARITY_EN
    logic         parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .start      (start),
        .ovr_clr    (ovr_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    typedef struct {
        logic [W-1:0] bits;
        logic         pbit;
        logic         rdy;
        logic [W-1:0] exp_dout;
        logic         exp_perr;
    } vec_t;

    vec_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First bit rides with start; dout_ready takes rdy_done in the completion cycle.
    task automatic send_frame(input logic [W-1:0] b, input logic pb, input logic rdy_done,
                              input bit chk_lat);
        for (int i = 0; i < W; i++) begin
            start  = (i == 0);
            ser_in = b[W-1-i];
`ifndef SIPO_PARITY_EN
            if (i == W-1) dout_ready = rdy_done;
`endif
            step();
            start = 1'b0;
            if (chk_lat && i == 0)   chk("busy_in_frame", 32'(busy), 32'd1);
            if (chk_lat && i == W-2) chk("valid_latency", 32'(dout_valid), 32'd0);
        end
`ifdef SIPO_PARITY_EN
        if (chk_lat) chk("valid_before_parity", 32'(dout_valid), 32'd0);
        ser_in     = pb;
        dout_ready = rdy_done;
        step();
`endif
        ser_in = 1'b0;
    endtask

    initial begin
        tbl[0] = '{bits: 4'b1011, pbit: 1'b1, rdy: 1'b0, exp_dout: 4'b1011, exp_perr: 1'b0};
        tbl[1] = '{bits: 4'b1011, pbit: 1'b0, rdy: 1'b0, exp_dout: 4'b1011, exp_perr: 1'b1};
        tbl[2] = '{bits: 4'b0000, pbit: 1'b0, rdy: 1'b1, exp_dout: 4'b0000, exp_perr: 1'b0};
        tbl[3] = '{bits: 4'b1111, pbit: 1'b1, rdy: 1'b0, exp_dout: 4'b1111, exp_perr: 1'b1};
        tbl[4] = '{bits: 4'b1001, pbit: 1'b1, rdy: 1'b1, exp_dout: 4'b1001, exp_perr: 1'b1};
        tbl[5] = '{bits: 4'b0110, pbit: 1'b0, rdy: 1'b0, exp_dout: 4'b0110, exp_perr: 1'b0};

        rst        = 1'b0;
        ser_in     = 1'b0;
        start      = 1'b0;
        ovr_clr    = 1'b0;
        dout_ready = 1'b0;
        step();
        step();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        step();

        // Table: each frame into an empty output, then consumed.
        for (int i = 0; i < 6; i++) begin
            dout_ready = 1'b0;
            send_frame(tbl[i].bits, tbl[i].pbit, tbl[i].rdy, 1'b1);
            chk("tbl_dout", 32'(dout), 32'(tbl[i].exp_dout));
            chk("tbl_valid", 32'(dout_valid), 32'd1);
            chk("tbl_overrun", 32'(overrun), 32'd0);
            chk("tbl_busy_idle", 32'(busy), 32'd0);
`ifdef SIPO_PARITY_EN
            chk("tbl_parity_err", 32'(parity_err), 32'(tbl[i].exp_perr));
`endif
            dout_ready = 1'b1;
            step();
            chk("tbl_accept_valid", 32'(dout_valid), 32'd0);
            chk("tbl_accept_dout_hold", 32'(dout), 32'(tbl[i].exp_dout));
            dout_ready = 1'b0;
        end

        // Back-to-back frames, consumer always ready.
        dout_ready = 1'b1;
        send_frame(4'b1010, 1'b0, 1'b1, 1'b0);
        chk("b2b_dout1", 32'(dout), 32'hA);
        chk("b2b_valid1", 32'(dout_valid), 32'd1);
        send_frame(4'b0110, 1'b0, 1'b1, 1'b0);
        chk("b2b_dout2", 32'(dout), 32'h6);
        chk("b2b_valid2", 32'(dout_valid), 32'd1);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        step();
        chk("b2b_drain", 32'(dout_valid), 32'd0);

        // Back-pressure: second word dropped, held word kept.
        dout_ready = 1'b0;
        send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
        chk("bp_dout1", 32'(dout), 32'hC);
        send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
        chk("bp_dout_hold", 32'(dout), 32'hC);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        chk("bp_overrun", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'd0);

        // Drop and clear in the same cycle: set must win.
        ovr_clr = 1'b1;
        send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        chk("ovr_dout_hold", 32'(dout), 32'hC);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clear2", 32'(overrun), 32'd0);

        // Completion in the same cycle the held word is accepted.
        send_frame(4'b0111, 1'b0, 1'b1, 1'b0);
        chk("coin_dout", 32'(dout), 32'h7);
        chk("coin_valid", 32'(dout_valid), 32'd1);
        chk("coin_overrun", 32'(overrun), 32'd0);
        step();
        chk("coin_drain", 32'(dout_valid), 32'd0);
        dout_ready = 1'b0;

        // Reset mid-frame with a word held.
        send_frame(4'b1110, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(dout_valid), 32'd1);
        start  = 1'b1;
        ser_in = 1'b1;
        step();
        start  = 1'b0;
        ser_in = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
`ifdef SIPO_PARITY_EN
        chk("midrst_parity_err", 32'(parity_err), 32'd0);
`endif
        step();
        rst = 1'b1;
        step();
        send_frame(4'b0101, 1'b0, 1'b0, 1'b1);
        chk("post_rst_dout", 32'(dout), 32'h5);
        chk("post_rst_valid", 32'(dout_valid), 32'd1);
        chk("post_rst_overrun", 32'(overrun), 32'd0);
`ifdef SIPO_PARITY_EN
        chk("post_rst_parity_err", 32'(parity_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
